// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between N_REQ producers, the arbiter and the UART transmitter.
//   req_val/req_data/req_rdy : per-producer valid/byte/ready handshake
//   uart_val/uart_data/uart_rdy : forwarded byte channel to the UART transmitter
//   uart_avail : host link present; low means every producer is drained
// The slave modport is the arbiter's view; master is the producers + UART side.
interface uart_tx_arbiter_if #(
  parameter int unsigned N_REQ = 2
);
  logic [N_REQ-1:0] req_val;
  logic [7:0]       req_data [0:N_REQ-1];
  logic [N_REQ-1:0] req_rdy;
  logic             uart_val;
  logic [7:0]       uart_data;
  logic             uart_rdy;
  logic             uart_avail;

  modport master (
    output req_val, req_data, uart_rdy, uart_avail,
    input  req_rdy, uart_val, uart_data
  );

  modport slave (
    input  req_val, req_data, uart_rdy, uart_avail,
    output req_rdy, uart_val, uart_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Line-granular round-robin arbiter sharing one UART transmit byte channel among N_REQ
// producers. A granted producer keeps the channel until it sends a line feed or stays quiet
// for TIMEOUT cycles. With the host link absent, all producers are drained.
//   clk_i    : clock, rising edge
//   rst_ni   : synchronous active-low reset
//   bus      : producer and UART handshakes (uart_tx_arbiter_if, slave view)
//   grant_o  : one-hot registered grant, zero when idle
//   busy_o   : high while a producer holds the channel
module uart_tx_arbiter #(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  uart_tx_arbiter_if.slave bus,
  output logic [N_REQ-1:0] grant_o,
  output logic             busy_o
);

  localparam int unsigned IdxW = $clog2(N_REQ);
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  localparam logic [CntW-1:0] CntLast  = CntW'(TIMEOUT - 1);
  localparam logic [IdxW-1:0] LastInit = IdxW'(N_REQ - 1);
  localparam logic [7:0]      LineFeed = 8'h0A;

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StLocked = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [IdxW-1:0] gnt_idx_q, gnt_idx_d;
  logic [IdxW-1:0] last_idx_q, last_idx_d;
  logic [CntW-1:0] idle_cnt_q, idle_cnt_d;

  logic            locked;
  logic            gnt_val;
  logic [7:0]      gnt_data;
  logic            xfer;
  logic            pick_found;
  logic [IdxW-1:0] pick_idx;

  assign locked   = (state_q == StLocked);
  assign gnt_val  = bus.req_val[gnt_idx_q];
  assign gnt_data = bus.req_data[gnt_idx_q];
  assign xfer     = bus.uart_avail && locked && gnt_val && bus.uart_rdy;

  // Round-robin search starting just after the last producer served; modulo keeps
  // non-power-of-two producer counts wrapping correctly.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      if (!pick_found && bus.req_val[(32'(last_idx_q) + k) % N_REQ]) begin
        pick_found = 1'b1;
        pick_idx   = IdxW'((32'(last_idx_q) + k) % N_REQ);
      end
    end
  end

  // Combinational forwarding; drain overrides everything.
  always_comb begin
    bus.req_rdy   = '0;
    bus.uart_val  = 1'b0;
    bus.uart_data = 8'h00;
    if (!bus.uart_avail) begin
      bus.req_rdy = '1;
    end else if (locked) begin
      bus.uart_val           = gnt_val;
      bus.uart_data          = gnt_val ? gnt_data : 8'h00;
      bus.req_rdy[gnt_idx_q] = bus.uart_rdy;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    last_idx_d = last_idx_q;
    idle_cnt_d = idle_cnt_q;
    if (!bus.uart_avail) begin
      state_d    = StIdle;
      idle_cnt_d = '0;
    end else if (!locked) begin
      if (pick_found) begin
        state_d    = StLocked;
        gnt_idx_d  = pick_idx;
        idle_cnt_d = '0;
      end
    end else if (xfer) begin
      idle_cnt_d = '0;
      if (gnt_data == LineFeed) begin
        state_d    = StIdle;
        last_idx_d = gnt_idx_q;
      end
    end else if (idle_cnt_q == CntLast) begin
      state_d    = StIdle;
      idle_cnt_d = '0;
      last_idx_d = gnt_idx_q;
    end else begin
      idle_cnt_d = idle_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      gnt_idx_q  <= '0;
      last_idx_q <= LastInit;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      last_idx_q <= last_idx_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  always_comb begin
    grant_o = '0;
    if (locked) grant_o[gnt_idx_q] = 1'b1;
  end

  assign busy_o = locked;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: producers and a reference model push expected
// per-cycle outputs and expected UART bytes; a separate monitor pops and compares.
module tb_uart_tx_arbiter;
  localparam int unsigned NReq    = 3;
  localparam int unsigned Timeout = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic [NReq-1:0] grant_o;
  logic            busy_o;

  uart_tx_arbiter_if #(.N_REQ(NReq)) bus_if ();

  uart_tx_arbiter #(.N_REQ(NReq), .TIMEOUT(Timeout)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus_if),
    .grant_o(grant_o),
    .busy_o (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [NReq-1:0] grant;
    logic            busy;
    logic [NReq-1:0] rdy;
    logic            uval;
    logic [7:0]      udata;
  } cyc_t;

  int          errors = 0;
  int          checks = 0;
  cyc_t        cyc_q[$];
  logic [7:0]  exp_bytes[$];
  logic [7:0]  out_log[$];
  int          gnt_log[$];
  logic [7:0]  pq [NReq][$];
  bit          active [NReq];
  logic [NReq-1:0] acc = '0;

  // Reference model: owner = -1 when nobody holds the line.
  int owner = -1;
  int last  = NReq - 1;
  int quiet = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_cycle(input bit urdy, input bit avail);
    cyc_t e;
    logic [NReq-1:0] val;
    e   = '0;
    val = bus_if.req_val;
    if (owner >= 0) begin
      e.grant[owner] = 1'b1;
      e.busy         = 1'b1;
    end
    if (!avail) begin
      e.rdy = '1;
      owner = -1;
      quiet = 0;
    end else if (owner < 0) begin
      for (int k = 1; k <= NReq; k++) begin
        if (owner < 0 && val[(last + k) % NReq]) begin
          owner = (last + k) % NReq;
          quiet = 0;
        end
      end
    end else begin
      e.rdy[owner] = urdy;
      if (val[owner]) begin
        e.uval  = 1'b1;
        e.udata = bus_if.req_data[owner];
      end
      if (val[owner] && urdy) begin
        exp_bytes.push_back(bus_if.req_data[owner]);
        quiet = 0;
        if (bus_if.req_data[owner] == 8'h0A) begin
          last  = owner;
          owner = -1;
        end
      end else begin
        quiet++;
        if (quiet == Timeout) begin
          last  = owner;
          owner = -1;
          quiet = 0;
        end
      end
    end
    cyc_q.push_back(e);
  endtask

  // Called right after a negedge; returns at the next negedge.
  task automatic step(input bit urdy, input bit avail);
    for (int i = 0; i < NReq; i++) if (acc[i]) void'(pq[i].pop_front());
    for (int i = 0; i < NReq; i++) begin
      bus_if.req_val[i]  = active[i] && (pq[i].size() > 0);
      bus_if.req_data[i] = bus_if.req_val[i] ? pq[i][0] : 8'($urandom);
    end
    bus_if.uart_rdy   = urdy;
    bus_if.uart_avail = avail;
    #1;
    model_cycle(urdy, avail);
    acc = bus_if.req_val & bus_if.req_rdy;
    @(negedge clk_i);
  endtask

  task automatic load(input int i, input string s);
    for (int k = 0; k < s.len(); k++) pq[i].push_back(s[k]);
  endtask

  function automatic bit all_done();
    bit d;
    d = (owner < 0) && (acc == '0);
    for (int i = 0; i < NReq; i++) if (pq[i].size() != 0) d = 1'b0;
    return d;
  endfunction

  task automatic run_until_empty(input int budget, input bit toggle_rdy);
    bit done;
    int n;
    done = 1'b0;
    n    = 0;
    while (!done && n < budget) begin
      step(toggle_rdy ? bit'(n % 2) : 1'b1, 1'b1);
      n++;
      done = all_done();
    end
    check("flush_budget", 32'(done), 32'd1);
  endtask

  task automatic check_log(input string name, input string s);
    check({name, "_len"}, out_log.size(), s.len());
    for (int k = 0; k < s.len() && k < out_log.size(); k++) check(name, out_log[k], s[k]);
  endtask

  task automatic clear_logs();
    out_log.delete();
    gnt_log.delete();
  endtask

  // Monitor: pops expectations and compares whenever the DUT presents a cycle or a byte.
  cyc_t            mon_e;
  logic [NReq-1:0] prev_grant = '0;
  initial begin
    forever begin
      @(negedge clk_i);
      #2;
      if (cyc_q.size() > 0) begin
        mon_e = cyc_q.pop_front();
        check("grant", grant_o, mon_e.grant);
        check("busy", busy_o, mon_e.busy);
        check("req_rdy", bus_if.req_rdy, mon_e.rdy);
        check("uart_val", bus_if.uart_val, mon_e.uval);
        check("uart_data", bus_if.uart_data, mon_e.udata);
        if (bus_if.uart_val && bus_if.uart_rdy) begin
          out_log.push_back(bus_if.uart_data);
          if (exp_bytes.size() == 0) check("byte_extra", 32'd1, 32'(exp_bytes.size()));
          else check("byte", bus_if.uart_data, exp_bytes.pop_front());
        end
        if (grant_o != '0 && prev_grant == '0) begin
          for (int i = 0; i < NReq; i++) if (grant_o[i]) gnt_log.push_back(i);
        end
        prev_grant = grant_o;
      end
    end
  end

  initial begin
    for (int i = 0; i < NReq; i++) begin
      active[i]          = 1'b1;
      bus_if.req_data[i] = 8'h41 + 8'(i);
    end
    rst_ni            = 1'b0;
    bus_if.req_val    = '1;
    bus_if.uart_rdy   = 1'b1;
    bus_if.uart_avail = 1'b1;

    repeat (3) begin
      @(negedge clk_i);
      #1;
      check("rst_grant", grant_o, '0);
      check("rst_uart_val", bus_if.uart_val, 1'b0);
      check("rst_req_rdy", bus_if.req_rdy, '0);
    end
    bus_if.uart_avail = 1'b0;
    #1;
    check("rst_drain_rdy", bus_if.req_rdy, {NReq{1'b1}});
    bus_if.uart_avail = 1'b1;
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Line atomicity: producer 0 first after reset, one bubble before producer 1.
    clear_logs();
    load(0, "12\n");
    load(1, "34\n");
    run_until_empty(50, 1'b0);
    check_log("atomic", "12\n34\n");
    check("atomic_gnt_n", gnt_log.size(), 32'd2);
    if (gnt_log.size() == 2) begin
      check("atomic_gnt0", gnt_log[0], 32'd0);
      check("atomic_gnt1", gnt_log[1], 32'd1);
    end

    // Backpressure: ready toggles every cycle.
    clear_logs();
    load(1, "5678\n");
    run_until_empty(60, 1'b1);
    check_log("backpr", "5678\n");

    // Timeout: producer 0 goes quiet after "9"; pending producer 1 follows.
    clear_logs();
    load(0, "9");
    load(1, "x\n");
    run_until_empty(60, 1'b0);
    check_log("timeout", "9x\n");

    // Drain mid-line: third byte is discarded, line resumes after re-grant.
    clear_logs();
    load(0, "abcdef\n");
    repeat (3) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    run_until_empty(60, 1'b0);
    check_log("drain", "abdef\n");

    // Fairness: single-LF lines from everyone rotate the grant.
    clear_logs();
    for (int i = 0; i < NReq; i++) load(i, "\n\n\n\n");
    run_until_empty(100, 1'b0);
    check("rr_len", gnt_log.size(), 32'(4 * NReq));
    for (int k = 1; k < gnt_log.size(); k++)
      check("rr_order", gnt_log[k], (gnt_log[k-1] + 1) % NReq);

    // Randomized traffic with stalls, valid gaps, missing LFs and link drops.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NReq; i++) begin
        if (pq[i].size() < 2 && $urandom_range(0, 3) == 0) begin
          int len;
          len = $urandom_range(1, 4);
          for (int k = 0; k < len; k++) pq[i].push_back(8'($urandom_range(97, 122)));
          if ($urandom_range(0, 4) != 0) pq[i].push_back(8'h0A);
        end
        if ($urandom_range(0, 7) == 0) active[i] = !active[i];
      end
      step($urandom_range(0, 3) != 0, $urandom_range(0, 49) != 0);
    end
    for (int i = 0; i < NReq; i++) active[i] = 1'b1;
    run_until_empty(600, 1'b0);

    #3;
    check("exp_bytes_left", exp_bytes.size(), 32'd0);
    check("cyc_left", cyc_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
